// File: rtl/watch_set_ctrl.sv
// Time-set controller: freezes the watch counter while hours/minutes are edited
// and writes the result back through a one-cycle load strobe.
module watch_set_ctrl #(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk_100MHz_i,
  input  logic       reset_n_i,
  input  logic       seconds_pulse_i,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  input  logic       dec_btn_i,
  input  logic [4:0] hours_i,
  input  logic [5:0] minutes_i,
  output logic       count_enable_o,
  output logic       load_time_o,
  output logic [6:0] load_seconds_o,
  output logic [5:0] load_minutes_o,
  output logic [4:0] load_hours_o,
  output logic [4:0] disp_hours_o,
  output logic [5:0] disp_minutes_o,
  output logic       editing_hours_o,
  output logic       editing_minutes_o,
  output logic       blink_o
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StSetH   = 2'd1,
    StSetM   = 2'd2,
    StCommit = 2'd3
  } state_e;

  localparam logic [5:0] IdleLast = 6'(TIMEOUT_S - 1);

  state_e     state_q, state_d;
  logic [4:0] edit_h_q, edit_h_d;
  logic [5:0] edit_m_q, edit_m_d;
  logic [5:0] idle_q, idle_d;
  logic       blink_q, blink_d;
  logic [4:0] load_h_q, load_h_d;
  logic [5:0] load_m_q, load_m_d;

  logic any_btn, step_up, step_dn;

  assign any_btn = mode_btn_i | inc_btn_i | dec_btn_i;
  assign step_up = inc_btn_i & ~dec_btn_i;
  assign step_dn = dec_btn_i & ~inc_btn_i;

  always_comb begin
    state_d  = state_q;
    edit_h_d = edit_h_q;
    edit_m_d = edit_m_q;
    idle_d   = idle_q;
    blink_d  = blink_q;
    load_h_d = load_h_q;
    load_m_d = load_m_q;

    unique case (state_q)
      StRun: begin
        if (mode_btn_i) begin
          state_d  = StSetH;
          edit_h_d = hours_i;
          edit_m_d = minutes_i;
          idle_d   = '0;
          blink_d  = 1'b1;
        end
      end
      StSetH, StSetM: begin
        if (seconds_pulse_i) begin
          blink_d = ~blink_q;
        end
        // Any button, even an ignored inc+dec pair, counts as activity.
        if (mode_btn_i) begin
          idle_d = '0;
          if (state_q == StSetH) begin
            state_d = StSetM;
          end else begin
            state_d  = StCommit;
            load_h_d = edit_h_q;
            load_m_d = edit_m_q;
          end
        end else if (any_btn) begin
          idle_d = '0;
          if (state_q == StSetH) begin
            if (step_up) edit_h_d = (edit_h_q == 5'd23) ? 5'd0 : edit_h_q + 5'd1;
            if (step_dn) edit_h_d = (edit_h_q == 5'd0) ? 5'd23 : edit_h_q - 5'd1;
          end else begin
            if (step_up) edit_m_d = (edit_m_q == 6'd59) ? 6'd0 : edit_m_q + 6'd1;
            if (step_dn) edit_m_d = (edit_m_q == 6'd0) ? 6'd59 : edit_m_q - 6'd1;
          end
        end else if (seconds_pulse_i) begin
          if (idle_q == IdleLast) begin
            state_d = StRun;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 6'd1;
          end
        end
      end
      StCommit: begin
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    if (state_d == StRun || state_d == StCommit) begin
      blink_d = 1'b0;
    end
  end

  always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= StRun;
      edit_h_q <= '0;
      edit_m_q <= '0;
      idle_q   <= '0;
      blink_q  <= 1'b0;
      load_h_q <= '0;
      load_m_q <= '0;
    end else begin
      state_q  <= state_d;
      edit_h_q <= edit_h_d;
      edit_m_q <= edit_m_d;
      idle_q   <= idle_d;
      blink_q  <= blink_d;
      load_h_q <= load_h_d;
      load_m_q <= load_m_d;
    end
  end

  always_comb begin
    count_enable_o    = (state_q == StRun);
    load_time_o       = (state_q == StCommit);
    editing_hours_o   = (state_q == StSetH);
    editing_minutes_o = (state_q == StSetM);
    load_seconds_o    = '0;
    load_hours_o      = load_h_q;
    load_minutes_o    = load_m_q;
    blink_o           = blink_q;
    if (state_q == StRun) begin
      disp_hours_o   = hours_i;
      disp_minutes_o = minutes_i;
    end else begin
      disp_hours_o   = edit_h_q;
      disp_minutes_o = edit_m_q;
    end
  end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl with a 3-second idle timeout.
module tb_watch_set_ctrl;

  logic       clk_100MHz_i = 1'b0;
  logic       reset_n_i;
  logic       seconds_pulse_i, mode_btn_i, inc_btn_i, dec_btn_i;
  logic [4:0] hours_i;
  logic [5:0] minutes_i;
  logic       count_enable_o, load_time_o;
  logic [6:0] load_seconds_o;
  logic [5:0] load_minutes_o;
  logic [4:0] load_hours_o;
  logic [4:0] disp_hours_o;
  logic [5:0] disp_minutes_o;
  logic       editing_hours_o, editing_minutes_o, blink_o;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  watch_set_ctrl #(.TIMEOUT_S(3)) dut (
    .clk_100MHz_i      (clk_100MHz_i),
    .reset_n_i         (reset_n_i),
    .seconds_pulse_i   (seconds_pulse_i),
    .mode_btn_i        (mode_btn_i),
    .inc_btn_i         (inc_btn_i),
    .dec_btn_i         (dec_btn_i),
    .hours_i           (hours_i),
    .minutes_i         (minutes_i),
    .count_enable_o    (count_enable_o),
    .load_time_o       (load_time_o),
    .load_seconds_o    (load_seconds_o),
    .load_minutes_o    (load_minutes_o),
    .load_hours_o      (load_hours_o),
    .disp_hours_o      (disp_hours_o),
    .disp_minutes_o    (disp_minutes_o),
    .editing_hours_o   (editing_hours_o),
    .editing_minutes_o (editing_minutes_o),
    .blink_o           (blink_o)
  );

  always #5 clk_100MHz_i = ~clk_100MHz_i;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given pulses held across the edge; returns 1 ns after it.
  task automatic step(input logic m, input logic i, input logic d, input logic s);
    mode_btn_i      = m;
    inc_btn_i       = i;
    dec_btn_i       = d;
    seconds_pulse_i = s;
    @(posedge clk_100MHz_i);
    #1;
    mode_btn_i      = 1'b0;
    inc_btn_i       = 1'b0;
    dec_btn_i       = 1'b0;
    seconds_pulse_i = 1'b0;
  endtask

  task automatic repeat_step(input int n, input logic i, input logic d);
    for (int k = 0; k < n; k++) step(1'b0, i, d, 1'b0);
  endtask

  initial begin
    reset_n_i       = 1'b0;
    seconds_pulse_i = 1'b0;
    mode_btn_i      = 1'b0;
    inc_btn_i       = 1'b0;
    dec_btn_i       = 1'b0;
    hours_i         = 5'd10;
    minutes_i       = 6'd20;
    #12;
    check_val("rst_count_en", count_enable_o, 1);
    check_val("rst_load_time", load_time_o, 0);
    check_val("rst_load_h", load_hours_o, 0);
    check_val("rst_load_m", load_minutes_o, 0);
    check_val("rst_load_s", load_seconds_o, 0);
    check_val("rst_blink", blink_o, 0);
    check_val("rst_editing", {editing_hours_o, editing_minutes_o}, 0);
    check_val("rst_disp", {disp_hours_o, disp_minutes_o}, {5'd10, 6'd20});
    @(negedge clk_100MHz_i);
    reset_n_i = 1'b1;

    // Enter SET_H capturing 10:20.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("seth_editing_h", editing_hours_o, 1);
    check_val("seth_count_en", count_enable_o, 0);
    check_val("seth_blink", blink_o, 1);
    hours_i   = 5'd5;
    minutes_i = 6'd33;
    #1;
    check_val("seth_disp_frozen", {disp_hours_o, disp_minutes_o}, {5'd10, 6'd20});

    // Hour wrap both ways.
    repeat_step(13, 1'b1, 1'b0);
    check_val("h_at_23", disp_hours_o, 23);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("h_wrap_up", disp_hours_o, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("h_wrap_dn", disp_hours_o, 23);
    repeat_step(8, 1'b1, 1'b0);
    check_val("h_at_7", disp_hours_o, 7);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("h_inc_dec_ignored", disp_hours_o, 7);

    // Mode with inc: advances, hour untouched.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("mode_inc_state", {editing_hours_o, editing_minutes_o}, 2'b01);
    check_val("mode_inc_h", disp_hours_o, 7);
    check_val("setm_disp_m", disp_minutes_o, 20);

    // Minute wrap both ways, then 45.
    repeat_step(39, 1'b1, 1'b0);
    check_val("m_at_59", disp_minutes_o, 59);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("m_wrap_up", disp_minutes_o, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("m_wrap_dn", disp_minutes_o, 59);
    repeat_step(14, 1'b0, 1'b1);
    check_val("m_at_45", disp_minutes_o, 45);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("m_inc_dec_ignored", disp_minutes_o, 45);
    check_val("setm_no_load", load_time_o, 0);

    // Commit: strobe for exactly one cycle; buttons during COMMIT ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("commit_strobe", load_time_o, 1);
    check_val("commit_load", {load_seconds_o, load_minutes_o, load_hours_o},
              {7'd0, 6'd45, 5'd7});
    check_val("commit_count_en", count_enable_o, 0);
    check_val("commit_disp", {disp_hours_o, disp_minutes_o}, {5'd7, 6'd45});
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("post_strobe", load_time_o, 0);
    check_val("post_count_en", count_enable_o, 1);
    check_val("post_editing", {editing_hours_o, editing_minutes_o}, 0);
    check_val("post_load_hold", {load_minutes_o, load_hours_o}, {6'd45, 5'd7});
    check_val("post_disp_live", {disp_hours_o, disp_minutes_o}, {5'd5, 6'd33});

    // Idle timeout from SET_M discards edits.
    hours_i   = 5'd12;
    minutes_i = 6'd34;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("to_setm", editing_minutes_o, 1);
    check_val("to_blink0", blink_o, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("to_blink1", blink_o, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("to_blink2", blink_o, 1);
    check_val("to_still_setm", editing_minutes_o, 1);
    hours_i = 5'd9;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("to_strobe0", load_time_o, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("to_run", {editing_hours_o, editing_minutes_o, count_enable_o}, 3'b001);
    check_val("to_strobe1", load_time_o, 0);
    check_val("to_blink_run", blink_o, 0);
    check_val("to_disp_live", {disp_hours_o, disp_minutes_o}, {5'd9, 6'd34});
    check_val("to_load_hold", {load_minutes_o, load_hours_o}, {6'd45, 5'd7});

    // A button on the terminal second wins and restarts the idle count.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("btn_wins_state", editing_hours_o, 1);
    check_val("btn_wins_h", disp_hours_o, 10);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("idle_restart", editing_hours_o, 1);

    // Asynchronous reset mid-edit.
    #3;
    reset_n_i = 1'b0;
    #1;
    check_val("arst_editing", {editing_hours_o, editing_minutes_o}, 0);
    check_val("arst_count_en", count_enable_o, 1);
    check_val("arst_blink", blink_o, 0);
    check_val("arst_load", {load_time_o, load_minutes_o, load_hours_o}, 0);
    check_val("arst_disp", {disp_hours_o, disp_minutes_o}, {5'd9, 6'd34});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
